// File: rtl/alu_serial_seq_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: control codes, FSM encodings and
// small decode helpers used by the top level.
package alu_serial_seq_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_SLT_FIX = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    typedef enum logic [1:0] {
        OpAnd = 2'b00,
        OpOr  = 2'b01,
        OpSum = 2'b10
    } slice_op_e;

    function automatic logic f_legal(input logic [3:0] f);
        return (f == ALU_AND) || (f == ALU_OR) || (f == ALU_ADD) ||
               (f == ALU_SUB) || (f == ALU_SLT);
    endfunction

    function automatic logic f_binv(input logic [3:0] f);
        return (f == ALU_SUB) || (f == ALU_SLT);
    endfunction

    function automatic slice_op_e f_op(input logic [3:0] f);
        if (f == ALU_AND) begin
            return OpAnd;
        end else if (f == ALU_OR) begin
            return OpOr;
        end
        return OpSum;
    endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// Combinational 1-bit ALU slice: optional B inversion into a full adder, then an
// AND/OR/sum output mux.
module alu_bit_slice (
    input  logic       a,
    input  logic       b,
    input  logic       binv,
    input  logic       cin,
    input  logic [1:0] op,
    output logic       y,
    output logic       sum,
    output logic       cout
);

    logic b_eff;

    always_comb begin
        b_eff = b ^ binv;
        sum   = a ^ b_eff ^ cin;
        cout  = (a & b_eff) | (a & cin) | (b_eff & cin);
        case (op)
            2'b00:   y = a & b;
            2'b01:   y = a | b;
            default: y = sum;
        endcase
    end

endmodule

// File: rtl/alu_serial_seq.sv
// Multi-cycle sequencer that drives one alu_bit_slice LSB-first across WIDTH-bit operands
// and reports result, zero/carry/overflow flags and a one-cycle done pulse.
module alu_serial_seq
    import alu_serial_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       F,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry_out,
    output logic             overflow,
    output logic             err
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [3:0]       f_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic             c_msb_in_q;
    logic             sum_msb_q;
    logic             cout_msb_q;
    logic [WIDTH-1:0] result_q;
    logic             busy_q;
    logic             zero_q;
    logic             carry_out_q;
    logic             overflow_q;
    logic             err_q;

    logic             slice_y;
    logic             slice_sum;
    logic             slice_cout;
    logic [1:0]       slice_op;
    logic [WIDTH-1:0] res_next;
    logic             is_arith;
    logic             slt_bit;

    always_comb begin
        slice_op = f_op(f_q);
        res_next = {slice_y, result_q[WIDTH-1:1]};
        is_arith = (f_q == ALU_ADD) || (f_q == ALU_SUB);
        // Sign of A-B corrected for signed overflow.
        slt_bit  = sum_msb_q ^ (c_msb_in_q ^ cout_msb_q);
    end

    alu_bit_slice u_slice (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .binv (f_binv(f_q)),
        .cin  (carry_q),
        .op   (slice_op),
        .y    (slice_y),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            f_q         <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            c_msb_in_q  <= 1'b0;
            sum_msb_q   <= 1'b0;
            cout_msb_q  <= 1'b0;
            result_q    <= '0;
            busy_q      <= 1'b0;
            zero_q      <= 1'b0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_sh_q  <= A;
                        b_sh_q  <= B;
                        f_q     <= F;
                        cnt_q   <= '0;
                        carry_q <= f_binv(F);
                        if (f_legal(F)) begin
                            state_q <= S_RUN;
                            busy_q  <= 1'b1;
                            err_q   <= 1'b0;
                        end else begin
                            state_q     <= S_DONE;
                            err_q       <= 1'b1;
                            result_q    <= '0;
                            zero_q      <= 1'b1;
                            carry_out_q <= 1'b0;
                            overflow_q  <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    carry_q  <= slice_cout;
                    result_q <= res_next;
                    if (cnt_q == CNT_LAST) begin
                        c_msb_in_q <= carry_q;
                        sum_msb_q  <= slice_sum;
                        cout_msb_q <= slice_cout;
                        if (f_q == ALU_SLT) begin
                            state_q <= S_SLT_FIX;
                        end else begin
                            state_q     <= S_DONE;
                            zero_q      <= (res_next == '0);
                            carry_out_q <= is_arith & slice_cout;
                            overflow_q  <= is_arith & (carry_q ^ slice_cout);
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_SLT_FIX: begin
                    result_q    <= {{(WIDTH-1){1'b0}}, slt_bit};
                    zero_q      <= ~slt_bit;
                    carry_out_q <= 1'b0;
                    overflow_q  <= 1'b0;
                    state_q     <= S_DONE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        busy      = busy_q;
        done      = (state_q == S_DONE);
        result    = result_q;
        zero      = zero_q;
        carry_out = carry_out_q;
        overflow  = overflow_q;
        err       = err_q;
    end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Scoreboard bench for alu_serial_seq at WIDTH=8: directed ops push expectations, a monitor
// pops and compares on every done pulse.
module tb_alu_serial_seq;
    import alu_serial_seq_pkg::*;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   F = 4'd0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         busy, done, zero, carry_out, overflow, err;
    logic [W-1:0] result;

    typedef struct {
        int           id;
        logic [W-1:0] res;
        logic         z;
        logic         c;
        logic         v;
        logic         e;
        int           lat;
        int           t0;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    alu_serial_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .F         (F),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .zero      (zero),
        .carry_out (carry_out),
        .overflow  (overflow),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int id, input logic [31:0] act,
                       input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s (op %0d): got %0h expected %0h", nm, id, act, expv);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending op");
            end else begin
                e = q.pop_front();
                chk("result", e.id, 32'(result), 32'(e.res));
                chk("zero", e.id, 32'(zero), 32'(e.z));
                chk("carry_out", e.id, 32'(carry_out), 32'(e.c));
                chk("overflow", e.id, 32'(overflow), 32'(e.v));
                chk("err", e.id, 32'(err), 32'(e.e));
                chk("latency", e.id, 32'(cyc - e.t0), 32'(e.lat));
            end
        end
    end

    task automatic run_op(input int id, input logic [3:0] f, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] res, input logic z,
                          input logic c, input logic v, input logic e, input int lat,
                          input logic exp_busy, input logic poke);
        exp_t x;
        logic busy_seen;
        bit   got_done;
        @(negedge clk);
        F = f;
        A = a;
        B = b;
        start = 1'b1;
        x = '{id: id, res: res, z: z, c: c, v: v, e: e, lat: lat, t0: cyc};
        q.push_back(x);
        @(negedge clk);
        start = 1'b0;
        busy_seen = 1'b0;
        got_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            busy_seen = busy_seen | busy;
            if (poke && i == 3) begin
                // Conflicting request while busy; must be dropped.
                F = ALU_ADD;
                A = 8'hFF;
                B = 8'hFF;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (!got_done) begin
            checks++;
            errors++;
            $display("FAIL timeout (op %0d): got no done expected done within 40 cycles", id);
        end
        chk("busy_seen", id, 32'(busy_seen), 32'(exp_busy));
    endtask

    task automatic chk_reset_outputs(input int id);
        chk("rst_result", id, 32'(result), 32'h0);
        chk("rst_zero", id, 32'(zero), 32'h0);
        chk("rst_carry", id, 32'(carry_out), 32'h0);
        chk("rst_ovf", id, 32'(overflow), 32'h0);
        chk("rst_err", id, 32'(err), 32'h0);
        chk("rst_busy", id, 32'(busy), 32'h0);
        chk("rst_done", id, 32'(done), 32'h0);
    endtask

    initial begin
        int done_cnt;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs(0);
        rst_n = 1'b1;

        //     id  F        A      B      result z     c     v     e     lat busy poke
        run_op(1, ALU_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 9,  1'b1, 1'b0);
        run_op(2, ALU_SUB, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 9,  1'b1, 1'b0);
        run_op(3, ALU_SLT, 8'hFE, 8'h03, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 10, 1'b1, 1'b0);
        run_op(4, ALU_SLT, 8'h7F, 8'h80, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 10, 1'b1, 1'b0);
        run_op(5, ALU_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 9,  1'b1, 1'b1);
        run_op(6, ALU_OR,  8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, 1'b0, 1'b0, 9,  1'b1, 1'b0);
        run_op(7, 4'b1111, 8'h55, 8'hAA, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1,  1'b0, 1'b0);
        run_op(8, ALU_ADD, 8'h01, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 9,  1'b1, 1'b0);

        // Abort an ADD with reset at cycle 4; no done may follow.
        @(negedge clk);
        F = ALU_ADD;
        A = 8'h10;
        B = 8'h20;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_outputs(9);
        rst_n = 1'b1;
        done_cnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk("abort_no_done", 9, 32'(done_cnt), 32'h0);

        run_op(10, ALU_ADD, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 9, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        chk("queue_empty", 99, 32'(q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion expected finish before 100us");
        $fatal(1);
    end

endmodule
